// File: rtl/wm_pkg.sv
// Shared types and helpers for the washing-machine sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
//
// Contents: wm_state_e (3-bit state encoding, IDLE=0), default phase times,
// wm_out_t (packed output bundle), wm_max() for width sizing, and
// wm_decode() which maps state + motor direction to the output bundle.
package wm_pkg;

    localparam int WM_STATE_W          = 3;
    localparam int WM_DEF_WASH_TIME    = 100;
    localparam int WM_DEF_RINSE_TIME   = 50;
    localparam int WM_DEF_SPIN_TIME    = 80;
    localparam int WM_DEF_NUM_RINSE    = 2;
    localparam int WM_DEF_REV_PERIOD   = 10;
    localparam int WM_DEF_FILL_TIMEOUT = 500;
    localparam int WM_DEF_DRAIN_TIMEOUT = 500;
    localparam int WM_RINSE_CNT_W      = 4;

    typedef enum logic [WM_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RINSE = 3'd4,
        ST_SPIN  = 3'd5,
        ST_FAULT = 3'd6
    } wm_state_e;

    typedef struct packed {
        logic fill;
        logic drain;
        logic cw;
        logic ccw;
        logic spin_fast;
        logic door_lock;
        logic busy;
        logic fault;
    } wm_out_t;

    function automatic int wm_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Moore decode: everything except done depends only on state (and dir
    // while agitating).
    function automatic wm_out_t wm_decode(input wm_state_e s, input logic dir);
        wm_out_t o;
        o = '0;
        case (s)
            ST_FILL: begin
                o.fill      = 1'b1;
                o.door_lock = 1'b1;
                o.busy      = 1'b1;
            end
            ST_WASH, ST_RINSE: begin
                o.cw        = ~dir;
                o.ccw       = dir;
                o.door_lock = 1'b1;
                o.busy      = 1'b1;
            end
            ST_DRAIN: begin
                o.drain     = 1'b1;
                o.door_lock = 1'b1;
                o.busy      = 1'b1;
            end
            ST_SPIN: begin
                o.cw        = 1'b1;
                o.spin_fast = 1'b1;
                o.door_lock = 1'b1;
                o.busy      = 1'b1;
            end
            ST_FAULT: begin
                o.drain     = 1'b1;
                o.door_lock = 1'b1;
                o.fault     = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Loadable down-counter shared by phase durations and sensor timeouts.
// Latency: load takes effect at the next edge; counts down 1 per cycle, holds at 0.
// Backpressure: none; load always wins over counting.
//
// Ports: clk, rst_n (sync, active-low), load, load_val[W-1:0], zero (count==0).
module wm_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/washing_machine_ctrl_v2.sv
// Washing-machine sequencer: fill/wash/drain, NUM_RINSE rinse loops, spin, abort, done pulse.
// Latency: outputs are registered and reflect the state entered at the last edge; done is a 1-cycle pulse.
// Backpressure: none; sensors and commands are level-sampled only in the states that use them.
//
// Ports: clk, rst_n (sync, active-low), start, abort, water_level_full, drain_empty,
// clear_fault -> fill_valve_on, drain_valve_on, motor_cw, motor_ccw, motor_off,
// spin_fast, door_lock, busy, done, fault, state_o[2:0].
// Build option WM_FAULT_TIMEOUT_EN: FILL/DRAIN timeouts send the machine to FAULT;
// when undefined FAULT is unreachable and clear_fault is ignored.
module washing_machine_ctrl_v2 import wm_pkg::*; #(
    parameter int WASH_TIME     = WM_DEF_WASH_TIME,
    parameter int RINSE_TIME    = WM_DEF_RINSE_TIME,
    parameter int SPIN_TIME     = WM_DEF_SPIN_TIME,
    parameter int NUM_RINSE     = WM_DEF_NUM_RINSE,
    parameter int REV_PERIOD    = WM_DEF_REV_PERIOD,
    parameter int FILL_TIMEOUT  = WM_DEF_FILL_TIMEOUT,
    parameter int DRAIN_TIMEOUT = WM_DEF_DRAIN_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       water_level_full,
    input  logic       drain_empty,
    input  logic       clear_fault,
    output logic       fill_valve_on,
    output logic       drain_valve_on,
    output logic       motor_cw,
    output logic       motor_ccw,
    output logic       motor_off,
    output logic       spin_fast,
    output logic       door_lock,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int TW = $clog2(wm_max(wm_max(WASH_TIME, RINSE_TIME),
                                      wm_max(SPIN_TIME, wm_max(FILL_TIMEOUT, DRAIN_TIMEOUT))) + 1);
    localparam int RW = (REV_PERIOD > 1) ? $clog2(REV_PERIOD) : 1;

    localparam logic [TW-1:0] LD_WASH  = TW'(WASH_TIME - 1);
    localparam logic [TW-1:0] LD_RINSE = TW'(RINSE_TIME - 1);
    localparam logic [TW-1:0] LD_SPIN  = TW'(SPIN_TIME - 1);
    localparam logic [TW-1:0] LD_FILL  = TW'(FILL_TIMEOUT - 1);
    localparam logic [TW-1:0] LD_DRAIN = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [RW-1:0] REV_LAST = RW'(REV_PERIOD - 1);
    localparam logic [WM_RINSE_CNT_W-1:0] RINSE_MAX = WM_RINSE_CNT_W'(NUM_RINSE);

    wm_state_e                  state, state_nx;
    logic [WM_RINSE_CNT_W-1:0]  rinse_cnt, rinse_cnt_nx;
    logic [RW-1:0]              rev_cnt, rev_cnt_nx;
    logic                       dir, dir_nx;
    logic                       aborting, aborting_nx;
    logic                       done_nx;
    logic                       tmr_load;
    logic [TW-1:0]              tmr_val;
    logic                       tmr_zero;
    wm_out_t                    out_q;
    logic                       done_q;

`ifndef WM_FAULT_TIMEOUT_EN
    wire unused_clear_fault = clear_fault;
`endif

    wm_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nx     = state;
        rinse_cnt_nx = rinse_cnt;
        rev_cnt_nx   = rev_cnt;
        dir_nx       = dir;
        aborting_nx  = aborting;
        done_nx      = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        // Motor reversal runs only while agitating; entry from FILL restarts it.
        if (state == ST_WASH || state == ST_RINSE) begin
            if (rev_cnt == REV_LAST) begin
                rev_cnt_nx = '0;
                dir_nx     = ~dir;
            end else begin
                rev_cnt_nx = rev_cnt + 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx     = ST_FILL;
                    rinse_cnt_nx = '0;
                    tmr_load     = 1'b1;
                    tmr_val      = LD_FILL;
                end
            end
            ST_FILL: begin
                // abort beats a same-cycle level event
                if (abort) begin
                    state_nx    = ST_DRAIN;
                    aborting_nx = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = LD_DRAIN;
                end else if (water_level_full) begin
                    state_nx   = (rinse_cnt == '0) ? ST_WASH : ST_RINSE;
                    tmr_load   = 1'b1;
                    tmr_val    = (rinse_cnt == '0) ? LD_WASH : LD_RINSE;
                    dir_nx     = 1'b0;
                    rev_cnt_nx = '0;
`ifdef WM_FAULT_TIMEOUT_EN
                end else if (tmr_zero) begin
                    state_nx = ST_FAULT;
`endif
                end
            end
            ST_WASH, ST_RINSE, ST_SPIN: begin
                if (abort) begin
                    state_nx    = ST_DRAIN;
                    aborting_nx = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = LD_DRAIN;
                end else if (tmr_zero) begin
                    if (state == ST_SPIN) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = ST_DRAIN;
                        tmr_load = 1'b1;
                        tmr_val  = LD_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    aborting_nx = 1'b1;
                end else if (drain_empty) begin
                    if (aborting) begin
                        state_nx    = ST_IDLE;
                        aborting_nx = 1'b0;
                    end else if (rinse_cnt < RINSE_MAX) begin
                        state_nx     = ST_FILL;
                        rinse_cnt_nx = rinse_cnt + 1'b1;
                        tmr_load     = 1'b1;
                        tmr_val      = LD_FILL;
                    end else begin
                        state_nx = ST_SPIN;
                        tmr_load = 1'b1;
                        tmr_val  = LD_SPIN;
                    end
`ifdef WM_FAULT_TIMEOUT_EN
                end else if (tmr_zero) begin
                    state_nx = ST_FAULT;
`endif
                end
            end
            ST_FAULT: begin
`ifdef WM_FAULT_TIMEOUT_EN
                if (clear_fault) begin
                    state_nx    = ST_IDLE;
                    aborting_nx = 1'b0;
                end
`endif
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rinse_cnt <= '0;
            rev_cnt   <= '0;
            dir       <= 1'b0;
            aborting  <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= wm_decode(ST_IDLE, 1'b0);
        end else begin
            state     <= state_nx;
            rinse_cnt <= rinse_cnt_nx;
            rev_cnt   <= rev_cnt_nx;
            dir       <= dir_nx;
            aborting  <= aborting_nx;
            done_q    <= done_nx;
            // decode the next state so outputs come straight from flops
            out_q     <= wm_decode(state_nx, dir_nx);
        end
    end

    assign fill_valve_on  = out_q.fill;
    assign drain_valve_on = out_q.drain;
    assign motor_cw       = out_q.cw;
    assign motor_ccw      = out_q.ccw;
    assign motor_off      = ~(out_q.cw | out_q.ccw);
    assign spin_fast      = out_q.spin_fast;
    assign door_lock      = out_q.door_lock;
    assign busy           = out_q.busy;
    assign fault          = out_q.fault;
    assign done           = done_q;
    assign state_o        = state;

endmodule

// File: tb/tb_washing_machine_ctrl_v2.sv
// Directed bench for washing_machine_ctrl_v2.
// dut0: WASH=20 RINSE=6 SPIN=8 NUM_RINSE=2 REV=4 timeouts=30.
// dut1: WASH=3 SPIN=5 NUM_RINSE=0 REV=2. Both share inputs; sel picks which one is checked.
module tb_washing_machine_ctrl_v2;

    localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_WASH = 3'd2, S_DRAIN = 3'd3,
                           S_RINSE = 3'd4, S_SPIN = 3'd5, S_FAULT = 3'd6;

    // {fill, drain, cw, ccw, off, spin, lock, busy, done, fault}
    localparam logic [9:0] V_IDLE  = 10'b0000100000;
    localparam logic [9:0] V_DONE  = 10'b0000100010;
    localparam logic [9:0] V_FILL  = 10'b1000101100;
    localparam logic [9:0] V_CW    = 10'b0010001100;
    localparam logic [9:0] V_CCW   = 10'b0001001100;
    localparam logic [9:0] V_DRAIN = 10'b0100101100;
    localparam logic [9:0] V_SPIN  = 10'b0010011100;
    localparam logic [9:0] V_FAULT = 10'b0100101001;

    logic clk = 1'b0;
    logic rst_n, start, abort, level, drain_empty, clear_fault;
    logic [1:0] fv, dv, cw, ccw, off, sf, dl, bz, dn, ft;
    logic [2:0] st0, st1;
    int sel = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    washing_machine_ctrl_v2 #(
        .WASH_TIME(20), .RINSE_TIME(6), .SPIN_TIME(8), .NUM_RINSE(2),
        .REV_PERIOD(4), .FILL_TIMEOUT(30), .DRAIN_TIMEOUT(30)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .water_level_full(level), .drain_empty(drain_empty), .clear_fault(clear_fault),
        .fill_valve_on(fv[0]), .drain_valve_on(dv[0]), .motor_cw(cw[0]), .motor_ccw(ccw[0]),
        .motor_off(off[0]), .spin_fast(sf[0]), .door_lock(dl[0]), .busy(bz[0]),
        .done(dn[0]), .fault(ft[0]), .state_o(st0)
    );

    washing_machine_ctrl_v2 #(
        .WASH_TIME(3), .RINSE_TIME(6), .SPIN_TIME(5), .NUM_RINSE(0),
        .REV_PERIOD(2), .FILL_TIMEOUT(500), .DRAIN_TIMEOUT(500)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .water_level_full(level), .drain_empty(drain_empty), .clear_fault(clear_fault),
        .fill_valve_on(fv[1]), .drain_valve_on(dv[1]), .motor_cw(cw[1]), .motor_ccw(ccw[1]),
        .motor_off(off[1]), .spin_fast(sf[1]), .door_lock(dl[1]), .busy(bz[1]),
        .done(dn[1]), .fault(ft[1]), .state_o(st1)
    );

    function automatic logic [9:0] outs(input int s);
        return {fv[s], dv[s], cw[s], ccw[s], off[s], sf[s], dl[s], bz[s], dn[s], ft[s]};
    endfunction

    // dut0 agitation pattern for REV_PERIOD=4: four CW cycles, four CCW, ...
    function automatic logic [9:0] agit4(input int i);
        return (((i / 4) % 2) != 0) ? V_CCW : V_CW;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Wait one cycle, drop all pulse inputs, check the selected DUT.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [9:0] eo);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; level = 1'b0; drain_empty = 1'b0; clear_fault = 1'b0;
        check({tag, "_state"}, (sel != 0) ? st1 : st0, es);
        check({tag, "_outs"}, outs(sel), eo);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; level = 1'b0;
        drain_empty = 1'b0; clear_fault = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state0", st0, S_IDLE);
        check("rst_outs0", outs(0), V_IDLE);
        check("rst_state1", st1, S_IDLE);
        check("rst_outs1", outs(1), V_IDLE);

        // T1/T2: full cycle with two rinses, reversal every 4 cycles
        rst_n = 1'b1; start = 1'b1;
        for (int i = 0; i < 5; i++) cyc("t1_fill", S_FILL, V_FILL);
        level = 1'b1;
        for (int i = 0; i < 20; i++) cyc("t2_wash", S_WASH, agit4(i));
        for (int i = 0; i < 3; i++) cyc("t1_drain", S_DRAIN, V_DRAIN);
        drain_empty = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) cyc("t1_rfill", S_FILL, V_FILL);
            level = 1'b1;
            for (int i = 0; i < 6; i++) cyc("t1_rinse", S_RINSE, agit4(i));
            for (int i = 0; i < 3; i++) cyc("t1_rdrain", S_DRAIN, V_DRAIN);
            drain_empty = 1'b1;
        end
        for (int i = 0; i < 8; i++) cyc("t1_spin", S_SPIN, V_SPIN);
        cyc("t1_done", S_IDLE, V_DONE);
        cyc("t1_idle", S_IDLE, V_IDLE);

        // T4: abort in the last WASH cycle (timer==0), abort beats drain_empty in DRAIN
        start = 1'b1; level = 1'b1;   // level held on entry edge is not sampled yet
        cyc("t4_fill", S_FILL, V_FILL);
        level = 1'b1;
        for (int i = 0; i < 20; i++) cyc("t4_wash", S_WASH, agit4(i));
        abort = 1'b1;
        cyc("t4_drain", S_DRAIN, V_DRAIN);
        abort = 1'b1; drain_empty = 1'b1;
        cyc("t4_drain_hold", S_DRAIN, V_DRAIN);
        drain_empty = 1'b1;
        cyc("t4_idle", S_IDLE, V_IDLE);
        abort = 1'b1;
        cyc("t4_idle_abort", S_IDLE, V_IDLE);

        // abort beats same-cycle level in FILL
        start = 1'b1;
        cyc("t4b_fill", S_FILL, V_FILL);
        level = 1'b1; abort = 1'b1;
        cyc("t4b_drain", S_DRAIN, V_DRAIN);
        drain_empty = 1'b1;
        cyc("t4b_idle", S_IDLE, V_IDLE);

        // abort at WASH cycle 7
        start = 1'b1;
        cyc("t4c_fill", S_FILL, V_FILL);
        level = 1'b1;
        for (int i = 0; i < 7; i++) cyc("t4c_wash", S_WASH, agit4(i));
        abort = 1'b1;
        cyc("t4c_drain", S_DRAIN, V_DRAIN);
        drain_empty = 1'b1;
        cyc("t4c_idle", S_IDLE, V_IDLE);

        // T5: start ignored while busy, reset during RINSE
        start = 1'b1;
        cyc("t5_fill", S_FILL, V_FILL);
        level = 1'b1;
        for (int i = 0; i < 20; i++) cyc("t5_wash", S_WASH, agit4(i));
        cyc("t5_drain", S_DRAIN, V_DRAIN);
        drain_empty = 1'b1;
        cyc("t5_rfill", S_FILL, V_FILL);
        level = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("t5_rinse", S_RINSE, agit4(i));
            start = 1'b1;
        end
        rst_n = 1'b0;
        cyc("t5_rst", S_IDLE, V_IDLE);
        rst_n = 1'b1;
        cyc("t5_idle", S_IDLE, V_IDLE);
        start = 1'b1;
        cyc("t5_fill2", S_FILL, V_FILL);
        level = 1'b1;
        cyc("t5_wash_after_rst", S_WASH, V_CW);
        abort = 1'b1;
        cyc("t5_drain2", S_DRAIN, V_DRAIN);
        drain_empty = 1'b1;
        cyc("t5_idle2", S_IDLE, V_IDLE);

        // T3: NUM_RINSE=0 goes DRAIN -> SPIN directly
        sel = 1;
        rst_n = 1'b0;
        cyc("t3_rst", S_IDLE, V_IDLE);
        rst_n = 1'b1; start = 1'b1;
        cyc("t3_fill", S_FILL, V_FILL);
        level = 1'b1;
        cyc("t3_wash0", S_WASH, V_CW);
        cyc("t3_wash1", S_WASH, V_CW);
        cyc("t3_wash2", S_WASH, V_CCW);
        cyc("t3_drain0", S_DRAIN, V_DRAIN);
        cyc("t3_drain1", S_DRAIN, V_DRAIN);
        drain_empty = 1'b1;
        for (int i = 0; i < 5; i++) cyc("t3_spin", S_SPIN, V_SPIN);
        cyc("t3_done", S_IDLE, V_DONE);
        cyc("t3_idle", S_IDLE, V_IDLE);

`ifdef WM_FAULT_TIMEOUT_EN
        // T6: level never arrives -> FAULT after 30 FILL cycles
        sel = 0;
        rst_n = 1'b0;
        cyc("t6_rst", S_IDLE, V_IDLE);
        rst_n = 1'b1; start = 1'b1;
        for (int i = 0; i < 30; i++) cyc("t6_fill", S_FILL, V_FILL);
        cyc("t6_fault", S_FAULT, V_FAULT);
        start = 1'b1; abort = 1'b1;
        cyc("t6_fault_hold", S_FAULT, V_FAULT);
        clear_fault = 1'b1;
        cyc("t6_clear", S_IDLE, V_IDLE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
